alu_result_collector: RTL

//  Receive-side companion of the pipelined ALU (hw5_unit).
//  - Captures every result leaving the ALU output stage (res, out_databits, out_op) into a FIFO.
//  - Presents captured results downstream over a valid/ready handshake.
//  - Hands flow-control credits back to the op issuer, so in-flight ops never exceed buffer space.
//  - Checks that result tags (out_databits) return in issue order.
//

---
 rtl/alu_result_collector.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_result_collector.sv
// Receive-side companion of the pipelined ALU: buffers returned results in a
// first-word-fall-through FIFO, returns issue credits and checks tag ordering.
module alu_result_collector #(
  parameter int WIDTH    = 32,
  parameter int DATABITS = 4,
  parameter int DEPTH    = 4,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue,
  output logic                can_issue,
  input  logic                res_valid,
  input  logic [WIDTH-1:0]    res,
  input  logic [DATABITS-1:0] out_databits,
  input  logic [1:0]          out_op,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [WIDTH-1:0]    o_res,
  output logic [DATABITS-1:0] o_tag,
  output logic [1:0]          o_op,
  output logic [CW-1:0]       count,
  input  logic                err_clr,
  output logic                seq_err,
  output logic                ovf_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [1:0]          op;
    logic [DATABITS-1:0] tag;
    logic [WIDTH-1:0]    res;
  } entry_t;

  entry_t              mem [DEPTH];
  entry_t              head;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count_q, count_nxt;
  logic [CW-1:0]       inflight, inflight_nxt;
  logic [DATABITS-1:0] exp_tag;
  logic [CW:0]         used;
  logic                full, push, pop;
  logic                issue_ok, ret_ok;
  logic                seq_evt, ovf_evt;
  logic                seq_err_q, ovf_err_q;

  // Flow-control decode from registered state only, so issue never loops back
  // combinationally into can_issue.
  assign used      = {1'b0, count_q} + {1'b0, inflight};
  assign can_issue = (used < (CW + 1)'(DEPTH));

  assign full     = (count_q == CW'(DEPTH));
  assign o_valid  = (count_q != '0);
  assign pop      = o_valid & o_ready;
  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign push     = res_valid & (~full | pop);
  assign issue_ok = issue & can_issue;
  assign ret_ok   = res_valid & (inflight != '0);

  assign seq_evt = res_valid & ((out_databits != exp_tag) | (inflight == '0));
  assign ovf_evt = (issue & ~can_issue) | (res_valid & full & ~pop);

  // NOTE: every signal written in always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_comb begin
    inflight_nxt = inflight;
    if (issue_ok && !ret_ok)      inflight_nxt = inflight + CW'(1);
    else if (!issue_ok && ret_ok) inflight_nxt = inflight - CW'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      inflight <= '0;
      exp_tag  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q  <= count_nxt;
      inflight <= inflight_nxt;
      // Always track the returned tag, so one bad tag flags once and resyncs.
      if (res_valid) exp_tag <= out_databits + DATABITS'(1);
    end
  end

  // NOTE: storage is deliberately not reset; entries are only observable while
  // count says they are valid, and the head is forced to zero otherwise.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: out_op, tag: out_databits, res: res};
  end

  // Sticky errors: a fresh event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      seq_err_q <= (seq_err_q & ~err_clr) | seq_evt;
      ovf_err_q <= (ovf_err_q & ~err_clr) | ovf_evt;
    end
  end

  assign head    = o_valid ? mem[rd_ptr] : '0;
  assign o_res   = head.res;
  assign o_tag   = head.tag;
  assign o_op    = head.op;
  assign count   = count_q;
  assign seq_err = seq_err_q;
  assign ovf_err = ovf_err_q;

endmodule
